// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU opcodes, forwarding selects
// and the multiplier state encoding.
package mips_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_MULT  = 4'b1001;
  localparam logic [3:0] ALU_MULTU = 4'b1010;
  localparam logic [3:0] ALU_MFHI  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;
  localparam logic [3:0] ALU_LUI   = 4'b1110;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  // Forwarding selects; 2'b11 is unused and falls back to the register file.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_DONE = 2'b10
  } mult_state_t;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/execute_stage_multiplier.sv
// Iterative shift-add multiplier owning HI/LO. Signed products are formed
// from operand magnitudes and negated once at the end.
module iterative_multiplier
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output mult_state_t       state
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_CYCLES - 1);

  mult_state_t         state_nx;
  logic [CNT_W-1:0]    count;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic                neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] prod;

  assign a_mag = (signed_op && a[DATA_W-1]) ? -a : a;
  assign b_mag = (signed_op && b[DATA_W-1]) ? -b : b;
  assign prod  = neg ? -acc : acc;
  assign busy  = (state != MS_IDLE);

  // State register; an asynchronous reset drops any partial product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MS_IDLE;
    else          state <= state_nx;
  end

  // Next state: IDLE -> RUN on start, RUN for MULT_CYCLES cycles, one DONE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      MS_IDLE: if (start) state_nx = MS_RUN;
      MS_RUN:  if (count == LAST_CNT) state_nx = MS_DONE;
      MS_DONE: state_nx = MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
  end

  // Datapath: latch magnitudes on start, one shift-add per RUN cycle, commit in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
            count  <= '0;
          end
        end
        MS_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        MS_DONE: {hi, lo} <= prod;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, iterative multiplier and EX/MEM register.
//
// Handshake: id_ex_valid marks a real instruction in ID/EX. ex_busy is the
// stage's not-ready; while it is high upstream holds ID/EX and the PC, and the
// EX/MEM register holds its (bubble) contents. An instruction is consumed on
// each clock edge where ex_busy is low.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int MULT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_ex_valid,
  input  logic [DATA_W-1:0] id_ex_rs_data,
  input  logic [DATA_W-1:0] id_ex_rt_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic [4:0]        id_ex_shamt,
  input  logic [3:0]        id_ex_alu_ctrl,
  input  logic              id_ex_alu_src,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_mem_write,
  input  logic              id_ex_mem_to_reg,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] mem_wb_fwd_data,
  input  logic              flush,
  output logic              ex_busy,
  output logic              ex_mem_valid,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write,
  output logic              ex_mem_mem_to_reg,
  output logic [REG_W-1:0]  ex_mem_rd,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output mult_state_t       dbg_mult_state
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              is_mult;
  logic              kill;
  logic              mult_start;

  assign is_mult    = is_mult_op(id_ex_alu_ctrl);
  assign kill       = flush | ex_busy | is_mult;
  assign mult_start = id_ex_valid & ~flush & is_mult & ~ex_busy;
  assign op_b       = id_ex_alu_src ? id_ex_imm : fwd_rt;

  // Forwarding muxes for rs and rt; 2'b11 behaves like the register file.
  always_comb begin
    op_a = id_ex_rs_data;
    case (forward_a)
      FWD_EXMEM: op_a = ex_mem_alu_result;
      FWD_MEMWB: op_a = mem_wb_fwd_data;
      default:   op_a = id_ex_rs_data;
    endcase
    fwd_rt = id_ex_rt_data;
    case (forward_b)
      FWD_EXMEM: fwd_rt = ex_mem_alu_result;
      FWD_MEMWB: fwd_rt = mem_wb_fwd_data;
      default:   fwd_rt = id_ex_rt_data;
    endcase
  end

  // Single-cycle ALU; MULT/MULTU produce no result here.
  always_comb begin
    alu_result = '0;
    case (id_ex_alu_ctrl)
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_NOR:  alu_result = ~(op_a | op_b);
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, op_a < op_b};
      ALU_SLL:  alu_result = op_b << id_ex_shamt;
      ALU_SRL:  alu_result = op_b >> id_ex_shamt;
      ALU_SRA:  alu_result = $signed(op_b) >>> id_ex_shamt;
      ALU_LUI:  alu_result = {id_ex_imm[15:0], {(DATA_W-16){1'b0}}};
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  iterative_multiplier #(
    .DATA_W      (DATA_W),
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mult_start),
    .signed_op (id_ex_alu_ctrl == ALU_MULT),
    .a         (op_a),
    .b         (fwd_rt),
    .busy      (ex_busy),
    .hi        (hi),
    .lo        (lo),
    .state     (dbg_mult_state)
  );

  // EX/MEM register: advances whenever the stage is not busy; killed ops become bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_rd         <= '0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
    end else if (!ex_busy) begin
      ex_mem_valid      <= id_ex_valid & ~kill;
      ex_mem_reg_write  <= id_ex_reg_write & ~kill;
      ex_mem_mem_read   <= id_ex_mem_read & ~kill;
      ex_mem_mem_write  <= id_ex_mem_write & ~kill;
      ex_mem_mem_to_reg <= id_ex_mem_to_reg;
      ex_mem_rd         <= id_ex_rd;
      ex_mem_alu_result <= alu_result;
      ex_mem_store_data <= fwd_rt;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle
// multiply/flush/reset sequences and randomized ALU and multiply traffic
// checked against an arithmetic reference model.
module tb_execute_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int MC = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          id_ex_valid;
  logic [DW-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]    id_ex_shamt;
  logic [3:0]    id_ex_alu_ctrl;
  logic          id_ex_alu_src;
  logic [RW-1:0] id_ex_rd;
  logic          id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
  logic [1:0]    forward_a, forward_b;
  logic [DW-1:0] mem_wb_fwd_data;
  logic          flush;
  logic          ex_busy;
  logic          ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg;
  logic [RW-1:0] ex_mem_rd;
  logic [DW-1:0] ex_mem_alu_result, ex_mem_store_data, hi, lo;
  mult_state_t   dbg_mult_state;

  execute_stage #(.DATA_W(DW), .REG_W(RW), .MULT_CYCLES(MC)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_ex_valid(id_ex_valid), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_shamt(id_ex_shamt), .id_ex_alu_ctrl(id_ex_alu_ctrl),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .forward_a(forward_a), .forward_b(forward_b),
    .mem_wb_fwd_data(mem_wb_fwd_data), .flush(flush), .ex_busy(ex_busy),
    .ex_mem_valid(ex_mem_valid), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_rd(ex_mem_rd),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .hi(hi), .lo(lo), .dbg_mult_state(dbg_mult_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_ex_valid = 0; id_ex_rs_data = 0; id_ex_rt_data = 0; id_ex_imm = 0;
    id_ex_shamt = 0; id_ex_alu_ctrl = ALU_AND; id_ex_alu_src = 0; id_ex_rd = 0;
    id_ex_reg_write = 0; id_ex_mem_read = 0; id_ex_mem_write = 0; id_ex_mem_to_reg = 0;
    forward_a = FWD_REG; forward_b = FWD_REG; mem_wb_fwd_data = 0; flush = 0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                          input logic [DW-1:0] imm, input logic [4:0] sh, input logic src,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [DW-1:0] memwb, input logic [RW-1:0] rd);
    id_ex_valid = 1; id_ex_alu_ctrl = op; id_ex_rs_data = rs; id_ex_rt_data = rt;
    id_ex_imm = imm; id_ex_shamt = sh; id_ex_alu_src = src; forward_a = fa; forward_b = fb;
    mem_wb_fwd_data = memwb; id_ex_rd = rd; id_ex_reg_write = 1; id_ex_mem_read = 0;
    id_ex_mem_write = 0; id_ex_mem_to_reg = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic longint to_signed(input logic [DW-1:0] v);
    return v[DW-1] ? longint'(v) - (longint'(1) << 32) : longint'(v);
  endfunction

  function automatic logic [DW-1:0] model_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [4:0] sh,
                                              input logic [DW-1:0] imm,
                                              input logic [DW-1:0] mhi, input logic [DW-1:0] mlo);
    longint r, p, sb;
    p  = longint'(1) << sh;
    sb = to_signed(b);
    r  = 0;
    case (op)
      ALU_AND:  r = longint'(a & b);
      ALU_OR:   r = longint'(a | b);
      ALU_XOR:  r = longint'(a ^ b);
      ALU_NOR:  r = longint'(~(a | b));
      ALU_ADD:  r = longint'(a) + longint'(b);
      ALU_SUB:  r = longint'(a) - longint'(b);
      ALU_SLT:  r = (to_signed(a) < sb) ? 1 : 0;
      ALU_SLTU: r = (longint'(a) < longint'(b)) ? 1 : 0;
      ALU_SLL:  r = longint'(b) * p;
      ALU_SRL:  r = longint'(b) / p;
      ALU_SRA:  r = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
      ALU_LUI:  r = (longint'(imm) % 65536) * 65536;
      ALU_MFHI: r = longint'(mhi);
      ALU_MFLO: r = longint'(mlo);
      default:  r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [63:0] model_mul(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] ua, ub;
    longint sp;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sp = to_signed(a) * to_signed(b);
    return sgn ? 64'(sp) : ua * ub;
  endfunction

  // Issue a multiply, hold MFLO behind it, count busy cycles and check results.
  task automatic run_mult(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit flush_mid);
    int busy_cnt;
    bit valid_seen;
    logic [63:0] exp;
    exp = model_mul(sgn, a, b);
    drive_op(sgn ? ALU_MULT : ALU_MULTU, a, b, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd3);
    tick();
    check("mult_issue_bubble", ex_mem_valid, 0);
    drive_op(ALU_MFLO, 0, 0, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd9);
    busy_cnt = 0;
    valid_seen = 0;
    for (int i = 0; i < MC + 8 && ex_busy; i++) begin
      busy_cnt++;
      if (ex_mem_valid) valid_seen = 1;
      flush = flush_mid && (i >= 5) && (i < 9);
      tick();
    end
    flush = 0;
    check("mult_busy_cycles", busy_cnt, MC + 1);
    check("mult_valid_during_busy", valid_seen, 0);
    check("mult_hi", hi, exp[63:32]);
    check("mult_lo", lo, exp[31:0]);
    tick();
    check("mflo_result", ex_mem_alu_result, exp[31:0]);
    check("mflo_valid", ex_mem_valid, 1);
    check("mflo_rd", ex_mem_rd, 9);
    drive_idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] rs, rt, imm;
    logic [4:0]    sh;
    logic          src;
    logic [1:0]    fb;
    logic [DW-1:0] memwb;
    logic [DW-1:0] exp_res;
    logic [DW-1:0] exp_st;
  } vec_t;

  vec_t vecs[14];
  logic [3:0] rand_ops[14];

  initial begin
    logic [DW-1:0] m_prev, m_hi, m_lo, rs, rt, imm, memwb, a, rt_f, b, e, got;
    logic [1:0] fa, fb;
    logic [4:0] sh;
    logic [3:0] op;
    logic src, fl;
    bit sgn;
    logic [63:0] mexp;

    vecs[0]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, FWD_REG, 0, 32'hF000F000, 32'hFF00FF00};
    vecs[1]  = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, FWD_REG, 0, 32'hFFF0FFF0, 32'hFF00FF00};
    vecs[2]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, FWD_REG, 0, 32'h0FF00FF0, 32'hFF00FF00};
    vecs[3]  = '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, FWD_REG, 0, 32'h000F000F, 32'hFF00FF00};
    vecs[4]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 0, 0, 0, FWD_REG, 0, 32'h00000000, 32'h00000001};
    vecs[5]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 0, 0, 0, FWD_REG, 0, 32'hFFFFFFFF, 32'h00000001};
    vecs[6]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 0, 0, 0, FWD_REG, 0, 32'h00000001, 32'h00000001};
    vecs[7]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, FWD_REG, 0, 32'h00000000, 32'h00000001};
    vecs[8]  = '{ALU_SLL,  32'h0, 32'h00000001, 0, 5'd31, 0, FWD_REG, 0, 32'h80000000, 32'h00000001};
    vecs[9]  = '{ALU_SRL,  32'h0, 32'h80000000, 0, 5'd4, 0, FWD_REG, 0, 32'h08000000, 32'h80000000};
    vecs[10] = '{ALU_SRA,  32'h0, 32'h80000000, 0, 5'd4, 0, FWD_REG, 0, 32'hF8000000, 32'h80000000};
    vecs[11] = '{ALU_LUI,  32'h0, 32'h000000AB, 32'h00001234, 0, 1, FWD_REG, 0, 32'h12340000, 32'h000000AB};
    vecs[12] = '{ALU_ADD,  32'h00000100, 32'h00000055, 32'h00000010, 0, 1, FWD_MEMWB, 32'hDEADBEEF,
                 32'h00000110, 32'hDEADBEEF};
    vecs[13] = '{ALU_ADD,  32'h00000002, 32'h00000003, 0, 0, 0, FWD_REG, 0, 32'h00000005, 32'h00000003};

    rand_ops = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT,
                 ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO};

    // Reset state
    drive_idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", ex_busy, 0);
    check("rst_valid", ex_mem_valid, 0);
    check("rst_reg_write", ex_mem_reg_write, 0);
    check("rst_result", ex_mem_alu_result, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_state", dbg_mult_state, MS_IDLE);
    @(negedge clk);
    reset_n = 1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      drive_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].sh, vecs[i].src,
               FWD_REG, vecs[i].fb, vecs[i].memwb, RW'(i));
      tick();
      check($sformatf("vec%0d_result", i), ex_mem_alu_result, vecs[i].exp_res);
      check($sformatf("vec%0d_store", i), ex_mem_store_data, vecs[i].exp_st);
      check($sformatf("vec%0d_valid", i), ex_mem_valid, 1);
      check($sformatf("vec%0d_rd", i), ex_mem_rd, i);
    end

    // EX/MEM forwarding on operand A: previous result 5 + rt 3
    drive_op(ALU_ADD, 32'hAAAA0000, 32'h3, 0, 0, 0, FWD_EXMEM, FWD_REG, 0, 5'd7);
    tick();
    check("fwd_exmem_result", ex_mem_alu_result, 32'h8);
    check("fwd_exmem_rd", ex_mem_rd, 7);

    // Flush turns a valid reg-writing store into a bubble
    drive_op(ALU_ADD, 32'h1, 32'h2, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd4);
    id_ex_mem_write = 1;
    flush = 1;
    tick();
    check("flush_valid", ex_mem_valid, 0);
    check("flush_reg_write", ex_mem_reg_write, 0);
    check("flush_mem_write", ex_mem_mem_write, 0);

    // A MULT flushed in its issue cycle never starts
    drive_op(ALU_MULT, 32'h7, 32'h9, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd4);
    flush = 1;
    tick();
    check("flushed_mult_busy", ex_busy, 0);
    drive_idle();
    tick();

    // Directed multiplies; the second one sees flush during RUN
    run_mult(1'b0, 32'hFFFFFFFD, 32'h5, 1'b0);
    run_mult(1'b1, 32'hFFFFFFFD, 32'h5, 1'b1);
    tick();

    // Reset pulsed mid-RUN discards the multiply
    drive_op(ALU_MULT, 32'h7, 32'h9, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd12);
    id_ex_mem_to_reg = 1;
    tick();
    drive_idle();
    repeat (9) tick();
    check("midrun_busy_before_reset", ex_busy, 1);
    reset_n = 0;
    #1;
    check("midrun_rst_busy", ex_busy, 0);
    check("midrun_rst_hi", hi, 0);
    check("midrun_rst_lo", lo, 0);
    check("midrun_rst_rd", ex_mem_rd, 0);
    check("midrun_rst_store", ex_mem_store_data, 0);
    check("midrun_rst_mem_to_reg", ex_mem_mem_to_reg, 0);
    check("midrun_rst_state", dbg_mult_state, MS_IDLE);
    @(negedge clk);
    reset_n = 1;
    drive_op(ALU_ADD, 32'h40, 32'h2, 0, 0, 0, 2'b11, FWD_REG, 32'h999, 5'd1);
    tick();
    check("fwd11_uses_rs", ex_mem_alu_result, 32'h42);
    check("fwd11_busy", ex_busy, 0);

    // Random multiplies against the 64-bit product model
    m_hi = 0;
    m_lo = 0;
    for (int i = 0; i < 6; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h80000000;
      run_mult(sgn, a, b, 1'($urandom_range(0, 1)));
      mexp = model_mul(sgn, a, b);
      m_hi = mexp[63:32];
      m_lo = mexp[31:0];
    end

    // Random single-cycle traffic with random forwarding and flushes
    drive_op(ALU_ADD, 32'h1234, 32'h0, 0, 0, 0, FWD_REG, FWD_REG, 0, 5'd2);
    tick();
    check("rand_seed_result", ex_mem_alu_result, 32'h1234);
    m_prev = 32'h1234;
    for (int i = 0; i < 60; i++) begin
      op = rand_ops[$urandom_range(0, 13)];
      rs = $urandom; rt = $urandom; imm = $urandom; memwb = $urandom;
      sh = 5'($urandom_range(0, 31));
      src = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 9) == 0);
      a    = (fa == FWD_EXMEM) ? m_prev : (fa == FWD_MEMWB) ? memwb : rs;
      rt_f = (fb == FWD_EXMEM) ? m_prev : (fb == FWD_MEMWB) ? memwb : rt;
      b    = src ? imm : rt_f;
      e    = model_alu(op, a, b, sh, imm, m_hi, m_lo);
      exp_q.push_back(e);
      drive_op(op, rs, rt, imm, sh, src, fa, fb, memwb, RW'(i));
      flush = fl;
      tick();
      got = exp_q.pop_front();
      check($sformatf("rand%0d_op%0h_result", i, op), ex_mem_alu_result, got);
      check($sformatf("rand%0d_store", i), ex_mem_store_data, rt_f);
      check($sformatf("rand%0d_valid", i), ex_mem_valid, !fl);
      m_prev = e;
    end
    drive_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX register.
- Applies forwardA/forwardB selects from the forwarding unit to the rs/rt operands and executes the ALU operation.
- Runs MULT/MULTU on an iterative multiplier that owns the HI/LO registers.
- Registers results into the EX/MEM pipeline register, whose rd/reg_write/result feed back to the forwarding unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-address width.
- MULT_CYCLES, 32, iterations of the shift-add multiplier. Must equal DATA_W.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_rs_data  in  DATA_W  rs register-file value.
- id_ex_rt_data  in  DATA_W  rt register-file value.
- id_ex_imm  in  DATA_W  sign-extended immediate.
- id_ex_shamt  in  5  shift amount.
- id_ex_alu_ctrl  in  4  ALU opcode (package codes).
- id_ex_alu_src  in  1  1 = operand B is imm.
- id_ex_rd  in  REG_W  final destination register.
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg  in  1 each  control bits.
- forward_a, forward_b  in  2 each  00 regfile, 10 EX/MEM, 01 MEM/WB, 11 treated as 00.
- mem_wb_fwd_data  in  DATA_W  writeback value.
- flush  in  1  kill the instruction currently in EX.
- ex_busy  out  1  multiplier active; upstream holds ID/EX and PC.
- ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg  out  1 each  registered control.
- ex_mem_rd  out  REG_W  registered destination.
- ex_mem_alu_result  out  DATA_W  registered result; also the EX/MEM forwarding source.
- ex_mem_store_data  out  DATA_W  registered forwarded rt.
- hi, lo  out  DATA_W  HI/LO registers.

Behaviour:
- Reset: all ex_mem_* = 0, hi = lo = 0, ex_busy = 0, FSM = IDLE, counter = 0. Reset is asynchronous and may occur mid-multiply; the partial product is discarded.
- Operand A = forward_a mux over {rs_data, ex_mem_alu_result, mem_wb_fwd_data}.
- fwd_rt = forward_b mux over the same three sources, using rt_data.
- Operand B = id_ex_alu_src ? imm : fwd_rt.
- store_data = fwd_rt, always. The immediate is never stored.
- ALU ops: AND, OR, XOR, NOR, ADD/SUB (wrap, no overflow trap), SLT (signed), SLTU, SLL/SRL/SRA (by shamt, shifting B), LUI (imm[15:0]<<16), MFHI, MFLO (result = hi/lo), MULT, MULTU.
- EX/MEM register updates every cycle in which ex_busy = 0. It captures the ALU result and control bits with valid = id_ex_valid.
- Bubble rule: valid, reg_write, mem_read and mem_write are forced to 0 when any of the following holds:
  - flush = 1;
  - ex_busy = 1;
  - the op is MULT/MULTU.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE -> RUN when id_ex_valid & !flush & op is MULT/MULTU (cycle T). Latch operands; for MULT latch magnitudes and record sign = a[31]^b[31]; counter = 0.
  - RUN: one shift-add bit per cycle. After MULT_CYCLES cycles (T+1..T+MULT_CYCLES) go to DONE.
  - DONE (cycle T+MULT_CYCLES+1): apply two's-complement negation if sign, write {hi,lo}, then go to IDLE.
- ex_busy = (state != IDLE), i.e. high T+1 .. T+MULT_CYCLES+1.
- The instruction held in ID/EX during busy (e.g. MFLO) executes at T+MULT_CYCLES+2 and sees the new HI/LO.
- flush asserted while RUN/DONE does not abort the multiply; the MULT is already committed.
- MULT with flush in its issue cycle never starts.
- Simultaneous DONE and MFHI/MFLO cannot occur, because the MFHI/MFLO is held by ex_busy.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_* 4-bit opcodes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, MULT 1001, MULTU 1010, MFHI 1011, NOR 1100, MFLO 1101, LUI 1110, SLTU 1111;
  - FWD_REG/FWD_EXMEM/FWD_MEMWB codes;
  - the multiplier state encoding.
- One sub-module, iterative_multiplier: FSM, counter and HI/LO. It has start, signed_op, a, b inputs and busy, hi, lo outputs.

Test Plan:
- ADD with forward_a=10, previous result ex_mem_alu_result=0x00000005, rt=0x3 -> next ex_mem_alu_result=0x00000008, ex_mem_rd propagated.
- SW with alu_src=1, imm=0x10, rs=0x100, forward_b=01, mem_wb_fwd_data=0xDEADBEEF -> alu_result=0x110, store_data=0xDEADBEEF.
- MULT rs=0xFFFFFFFD(-3), rt=5 -> ex_busy high exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU of the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- MFLO issued immediately after MULT -> held while busy; result 0xFFFFFFF1 appears in EX/MEM one cycle after ex_busy falls; ex_mem_valid=0 throughout busy.
- flush=1 with a valid reg-writing ADD -> ex_mem_valid=0 and ex_mem_reg_write=0 next cycle; flush during RUN -> multiply still completes with correct HI/LO.
- reset_n pulsed low mid-RUN (cycle 10) -> ex_busy=0, hi=lo=0, all ex_mem_* = 0 immediately; forward_a=11 on the next ADD -> uses rs_data.
